systolic_job_controller: RTL and testbench
==========================================

# systolic_job_controller

Host-side initiator for the systolic-array accelerator. It accepts a matrix-multiply job descriptor, fetches A and B from a single-port job memory into holding registers, and drives them onto the accelerator's parallel inputs. It then pulses `start`, waits for `done` under a timeout, and writes the C result back to memory. It sits between the system memory/host fabric and `accelerator_IP_systolicarray`, and owns the accelerator's start/done protocol.

## Interface
- `SIZE`, 4: matrix dimension, N×N.
- `DATAWIDTH`, 16: element width.
- `ADDRW`, 16: memory word-address width.
- `TIMEOUT`, 1024: maximum cycles in WAIT before the job is aborted with an error.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `job_valid` in 1: job descriptor valid.
- `job_ready` out 1: high only in IDLE.
- `job_addr_a`, `job_addr_b`, `job_addr_c` in ADDRW each: base addresses. Row-major; element (i,j) is at base+i*SIZE+j.
- `job_done` out 1: one-cycle pulse at the end of a job.
- `job_err` out 1: valid with `job_done`; 1 means timeout.
- `mem_rd_en` out 1, `mem_rd_addr` out ADDRW, `mem_rd_data` in DATAWIDTH: read port, data returns exactly 1 cycle after `mem_rd_en`.
- `mem_wr_en` out 1, `mem_wr_addr` out ADDRW, `mem_wr_data` out DATAWIDTH: write port, write takes effect the same cycle.
- `acc_dim` out 8: constant SIZE, drives depth_A/width_A/depth_B/width_B.
- `acc_a` out [SIZE][SIZE][DATAWIDTH]: A holding registers, maps to a_in_i_j.
- `acc_b` out [SIZE][SIZE][DATAWIDTH]: B holding registers, maps to b_in_i_j.
- `acc_start` out 1: one-cycle start pulse.
- `acc_done` in 1: accelerator completion, level or pulse.
- `acc_dout` in [SIZE][SIZE][DATAWIDTH]: accelerator results.

## Operation
- **State machine:** IDLE → LOAD → DRAIN → START → WAIT → STORE → FIN → IDLE.
- **IDLE:**
  - `job_ready`=1.
  - On `job_valid`: latch the three bases, clear counter k, go to LOAD.
- **LOAD:** issues 2·N² reads, one per cycle.
  - For k<N²: address is addr_a+k.
  - For k≥N²: address is addr_b+(k−N²).
  - Returned data from the read issued in the previous cycle is written to `acc_a` or `acc_b` element [idx/N][idx%N].
  - After the last read, go to DRAIN.
- **DRAIN:** captures the final B element; `mem_rd_en`=0.
- **START:**
  - `acc_start`=1 for exactly this cycle.
  - Clear the timeout counter.
  - `acc_done` is ignored in this cycle.
- **WAIT:**
  - On the first cycle with `acc_done`=1, snapshot `acc_dout` into internal C registers and go to STORE.
  - If the counter reaches TIMEOUT first, set the error flag and go to FIN with no writes.
- **STORE:** N² writes, one per cycle, of C[k/N][k%N] to addr_c+k. Then go to FIN.
- **FIN:** `job_done`=1 and `job_err`=error flag, then go to IDLE.
- **Hold behaviour:**
  - `acc_a`/`acc_b` keep their values from DRAIN until the next job's LOAD overwrites them.
  - Changes to `acc_dout` after the snapshot are ignored.
- **Address arithmetic:** ADDRW-bit modulo addition; wrap-around past 2^ADDRW−1 is legal and silent.
- **`acc_done` outside WAIT:** ignored.
- **`job_valid` outside IDLE:** ignored. The descriptor is not latched.

## Timing
- **Reset values:** at the reset edge, state=IDLE and all registered outputs are 0, including `acc_a`, `acc_b`, C, counters, `acc_start`, `job_done`, `job_err`, `mem_*_en`. `job_ready`=1 from the first cycle after reset.
- **Reset mid-job:** abort on the reset edge. After that edge there are no further reads, writes, `acc_start` or `job_done`.
- **Cycle-level schedule,** with cycle 0 the acceptance cycle:
  - Reads occur in cycles 1..2N² (1..32 for N=4).
  - DRAIN is cycle 2N²+1 (33).
  - START is cycle 2N²+2 (34).
  - WAIT begins at cycle 35.
  - If `acc_done` is first seen in cycle D: writes occur in D+1..D+N², FIN is D+N²+1, `job_ready` is 1 at D+N²+2.
- **No-timeout bound:** the timeout fires when WAIT has lasted TIMEOUT cycles. FIN follows in the next cycle.
- **Port exclusivity:** `mem_rd_en` and `mem_wr_en` are never both high.
- **Back-to-back jobs:** a new job may be accepted the cycle after FIN.

## Structure
- Shared `systolic_pkg` holds:
  - SIZE and DATAWIDTH defaults.
  - The state enum `sjc_state_t`.
  - Matrix typedef `mat_t` = logic [SIZE-1:0][SIZE-1:0][DATAWIDTH-1:0].
- One sub-module is natural: `sjc_addr_gen`. It contains the k counter plus base selection, and produces the read/write address, the last-element flag and the row/column index.
- The FSM, holding registers and timeout counter live in the top-level module.

## Test plan
- **Nominal job:** A={{5,2,6,1},{0,6,2,0},{3,8,1,4},{1,8,5,6}} and B={{7,5,8,0},{1,8,2,6},{9,4,3,8},{5,3,7,9}} at 0x000/0x010; a behavioural accelerator model returns A·B with `done` 5 cycles after start. Required:
  - memory at 0x020 = 96 and at 0x021 = 68.
  - `job_done` in cycle D+17 with `job_err`=0.
  - exactly 32 reads, then 16 writes.
- **Timeout:** TIMEOUT=8 and `acc_done` never asserted. Required: `job_done` with `job_err`=1 in cycle 34+8+1, and zero writes.
- **Reset mid-LOAD:** reset at cycle 10. Required: no `mem_rd_en` after the reset edge, `acc_start` never asserted, `job_ready`=1 next cycle.
- **Back-to-back jobs:** two jobs with `job_valid` held high. Required:
  - the second is accepted the cycle after the first FIN.
  - `job_valid` during the busy period is not latched.
  - `acc_start` pulses exactly twice.
- **Address wrap:** ADDRW=8, addr_c=0xF8. Required: writes go to 0xF8..0xFF then 0x00..0x07, with values correct.

Source files
------------

// File: rtl/systolic_job_controller_pkg.sv
// Shared types for the systolic job controller.
// Matrix geometry, FSM state encoding and holding-register type.
package systolic_pkg;

  localparam int SIZE      = 4;
  localparam int DATAWIDTH = 16;
  localparam int NN        = SIZE * SIZE;
  localparam int KW        = $clog2(2 * NN);
  localparam int RW        = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef logic [SIZE-1:0][SIZE-1:0][DATAWIDTH-1:0] mat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_START,
    S_WAIT,
    S_STORE,
    S_FIN
  } sjc_state_t;

endpackage

// File: rtl/systolic_job_controller_if.sv
// Job, memory and accelerator bundle of the systolic job controller.
// master = controller side, slave = host/memory/accelerator side.
interface systolic_job_controller_if
  import systolic_pkg::*;
#(
  parameter int ADDRW = 16
) ();

  logic                 job_valid;
  logic                 job_ready;
  logic [ADDRW-1:0]     job_addr_a;
  logic [ADDRW-1:0]     job_addr_b;
  logic [ADDRW-1:0]     job_addr_c;
  logic                 job_done;
  logic                 job_err;

  logic                 mem_rd_en;
  logic [ADDRW-1:0]     mem_rd_addr;
  logic [DATAWIDTH-1:0] mem_rd_data;
  logic                 mem_wr_en;
  logic [ADDRW-1:0]     mem_wr_addr;
  logic [DATAWIDTH-1:0] mem_wr_data;

  logic [7:0]           acc_dim;
  mat_t                 acc_a;
  mat_t                 acc_b;
  logic                 acc_start;
  logic                 acc_done;
  mat_t                 acc_dout;

  modport master (
    input  job_valid, job_addr_a, job_addr_b, job_addr_c,
    output job_ready, job_done, job_err,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output acc_dim, acc_a, acc_b, acc_start,
    input  acc_done, acc_dout
  );

  modport slave (
    output job_valid, job_addr_a, job_addr_b, job_addr_c,
    input  job_ready, job_done, job_err,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  acc_dim, acc_a, acc_b, acc_start,
    output acc_done, acc_dout
  );

endinterface

// File: rtl/systolic_job_controller_addr_gen.sv
// Element counter for the job controller: produces read/write
// addresses, last-element flags and the row/column of element k.
module sjc_addr_gen
  import systolic_pkg::*;
#(
  parameter int ADDRW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [ADDRW-1:0] base_a,
  input  logic [ADDRW-1:0] base_b,
  input  logic [ADDRW-1:0] base_c,
  output logic [ADDRW-1:0] rd_addr,
  output logic [ADDRW-1:0] wr_addr,
  output logic             last_rd,
  output logic             last_wr,
  output logic             is_b,
  output logic [RW-1:0]    row,
  output logic [RW-1:0]    col
);

  logic [KW-1:0] k;
  logic [KW-1:0] elem;

  always_ff @(posedge clk) begin
    if (reset) begin
      k <= '0;
    end else if (clr) begin
      k <= '0;
    end else if (inc) begin
      k <= k + KW'(1);
    end
  end

  // Reads walk A then B; elem is the index within the current matrix.
  assign is_b    = (k >= KW'(NN));
  assign elem    = is_b ? (k - KW'(NN)) : k;
  assign rd_addr = (is_b ? base_b : base_a) + ADDRW'(elem);
  assign wr_addr = base_c + ADDRW'(k);
  assign last_rd = (k == KW'(2 * NN - 1));
  assign last_wr = (k == KW'(NN - 1));
  assign row     = RW'(int'(elem) / SIZE);
  assign col     = RW'(int'(elem) % SIZE);

endmodule

// File: rtl/systolic_job_controller.sv
// Host-side job initiator for the systolic array: loads A/B from
// memory, runs the accelerator under a timeout, writes C back.
module systolic_job_controller
  import systolic_pkg::*;
#(
  parameter int ADDRW   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic                       clk,
  input logic                       reset,
  systolic_job_controller_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  sjc_state_t       state;
  logic [ADDRW-1:0] base_a;
  logic [ADDRW-1:0] base_b;
  logic [ADDRW-1:0] base_c;
  mat_t             a_q;
  mat_t             b_q;
  mat_t             c_q;
  logic [TW-1:0]    tcnt;

  logic             rd_en;
  logic             wr_en;
  logic             start;
  logic             done;
  logic             err;

  logic             cap_en;
  logic             cap_b;
  logic [RW-1:0]    cap_row;
  logic [RW-1:0]    cap_col;

  logic             clr;
  logic             inc;
  logic [ADDRW-1:0] rd_addr;
  logic [ADDRW-1:0] wr_addr;
  logic             last_rd;
  logic             last_wr;
  logic             is_b;
  logic [RW-1:0]    row;
  logic [RW-1:0]    col;

  assign clr = (state == S_IDLE) || (state == S_DRAIN);
  assign inc = ((state == S_LOAD) && !last_rd) ||
               ((state == S_STORE) && !last_wr);

  sjc_addr_gen #(
    .ADDRW (ADDRW)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc     (inc),
    .base_a  (base_a),
    .base_b  (base_b),
    .base_c  (base_c),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .last_rd (last_rd),
    .last_wr (last_wr),
    .is_b    (is_b),
    .row     (row),
    .col     (col)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      base_a  <= '0;
      base_b  <= '0;
      base_c  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      tcnt    <= '0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      start   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cap_en  <= 1'b0;
      cap_b   <= 1'b0;
      cap_row <= '0;
      cap_col <= '0;
    end else begin
      // Read data lags its address by one cycle; remember the target.
      cap_en  <= (state == S_LOAD);
      cap_b   <= is_b;
      cap_row <= row;
      cap_col <= col;
      if (cap_en) begin
        if (cap_b) b_q[cap_row][cap_col] <= bus.mem_rd_data;
        else       a_q[cap_row][cap_col] <= bus.mem_rd_data;
      end

      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (bus.job_valid) begin
            base_a <= bus.job_addr_a;
            base_b <= bus.job_addr_b;
            base_c <= bus.job_addr_c;
            rd_en  <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (last_rd) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          start <= 1'b1;
          state <= S_START;
        end
        S_START: begin
          start <= 1'b0;
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.acc_done) begin
            c_q   <= bus.acc_dout;
            wr_en <= 1'b1;
            state <= S_STORE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_FIN;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_STORE: begin
          if (last_wr) begin
            wr_en <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b0;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.job_ready   = (state == S_IDLE);
  assign bus.job_done    = done;
  assign bus.job_err     = err;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_addr = wr_addr;
  assign bus.mem_wr_data = c_q[row][col];
  assign bus.acc_dim     = 8'(SIZE);
  assign bus.acc_a       = a_q;
  assign bus.acc_b       = b_q;
  assign bus.acc_start   = start;

endmodule

// File: tb/tb_systolic_job_controller.sv
// Directed bench for systolic_job_controller with memory and
// behavioural accelerator models; 8-bit addresses, timeout of 8.
module tb_systolic_job_controller;
  import systolic_pkg::*;

  localparam int AW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  systolic_job_controller_if #(.ADDRW(AW)) bus ();

  systolic_job_controller #(
    .ADDRW   (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  int av [16] = '{5,2,6,1, 0,6,2,0, 3,8,1,4, 1,8,5,6};
  int bv [16] = '{7,5,8,0, 1,8,2,6, 9,4,3,8, 5,3,7,9};

  // memory model: 1-cycle read latency, preload port for the bench
  logic [15:0]   mem [256];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [15:0]   ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // accelerator model: done rises lat cycles after start (0 = never)
  int         lat = 5;
  logic [7:0] acnt = '0;

  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t        c;
    logic [15:0] s;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        s = '0;
        for (int k = 0; k < SIZE; k++) s = s + a[i][k] * b[k][j];
        c[i][j] = s;
      end
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (bus.acc_start) begin
      acnt         <= 8'd1;
      bus.acc_dout <= matmul(bus.acc_a, bus.acc_b);
    end else if (acnt != 8'd0 && acnt != 8'hff) begin
      acnt <= acnt + 8'd1;
    end
  end
  assign bus.acc_done = (lat != 0) && (int'(acnt) >= lat);

  // monitor, sampled on the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0, wr_cnt = 0, start_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int excl_bad = 0;
  int rd_first = 0, rd_last = 0, wr_first = 0, wr_last = 0;
  int start_cyc = 0, done_err = 0;
  int wlog [256];
  int dlog [16];
  int alog [16];
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_rd_en) begin
      if (!prev_rd) rd_first = cyc;
      rd_last = cyc;
      rd_cnt++;
    end
    if (bus.mem_wr_en) begin
      if (!prev_wr) wr_first = cyc;
      wr_last = cyc;
      wlog[wr_cnt % 256] = int'(bus.mem_wr_addr);
      wr_cnt++;
    end
    if (bus.mem_rd_en && bus.mem_wr_en) excl_bad++;
    if (bus.acc_start) begin
      start_cyc = cyc;
      start_cnt++;
    end
    if (bus.job_done) begin
      dlog[done_cnt % 16] = cyc;
      done_err = int'(bus.job_err);
      done_cnt++;
    end
    if (bus.job_valid && bus.job_ready && !reset) begin
      alog[acc_cnt % 16] = cyc;
      acc_cnt++;
    end
    prev_rd = bus.mem_rd_en;
    prev_wr = bus.mem_wr_en;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int addr, input int data);
    ld_en   = 1'b1;
    ld_addr = AW'(addr);
    ld_data = 16'(data);
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic submit(input int a, input int b, input int c);
    int a0;
    a0 = acc_cnt;
    @(posedge clk);
    #1;
    bus.job_addr_a = AW'(a);
    bus.job_addr_b = AW'(b);
    bus.job_addr_c = AW'(c);
    bus.job_valid  = 1'b1;
    for (int i = 0; i < 100 && acc_cnt == a0; i++) begin
      @(posedge clk);
      #1;
    end
    bus.job_valid = 1'b0;
    check("accept_timeout", 32'(acc_cnt > a0), 1);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && done_cnt < n; i++) begin
      @(posedge clk);
      #1;
    end
    check("done_timeout", 32'(done_cnt >= n), 1);
  endtask

  int a0, d0, r0, w0, s0;

  initial begin
    bus.job_valid  = 1'b0;
    bus.job_addr_a = '0;
    bus.job_addr_b = '0;
    bus.job_addr_c = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.job_ready), 1);
    check("rst_rd_en", 32'(bus.mem_rd_en), 0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 0);
    check("rst_start", 32'(bus.acc_start), 0);
    check("rst_done",  32'(bus.job_done), 0);
    check("rst_acc_a", 32'(bus.acc_a == '0), 1);
    check("acc_dim",   32'(bus.acc_dim), 4);

    for (int i = 0; i < 16; i++) load_word(i, av[i]);
    for (int i = 0; i < 16; i++) load_word(16 + i, bv[i]);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // nominal job, done 5 cycles after start
    lat = 5;
    a0 = acc_cnt; d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    s0 = start_cnt;
    submit(8'h00, 8'h10, 8'h20);
    wait_done(d0 + 1);
    check("nom_rd_count",  32'(rd_cnt - r0), 32);
    check("nom_rd_first",  32'(rd_first - alog[a0]), 1);
    check("nom_rd_last",   32'(rd_last - alog[a0]), 32);
    check("nom_start_cyc", 32'(start_cyc - alog[a0]), 34);
    check("nom_start_cnt", 32'(start_cnt - s0), 1);
    check("nom_wr_count",  32'(wr_cnt - w0), 16);
    check("nom_wr_first",  32'(wr_first - alog[a0]), 40);
    check("nom_wr_last",   32'(wr_last - alog[a0]), 55);
    check("nom_wr_addr0",  32'(wlog[w0]), 32'h20);
    check("nom_done_cyc",  32'(dlog[d0] - alog[a0]), 56);
    check("nom_done_err",  32'(done_err), 0);
    check("nom_c00", 32'(mem[8'h20]), 96);
    check("nom_c01", 32'(mem[8'h21]), 68);
    check("nom_c12", 32'(mem[8'h26]), 18);
    check("nom_c20", 32'(mem[8'h28]), 58);
    check("nom_c33", 32'(mem[8'h2F]), 142);
    check("nom_a21", 32'(bus.acc_a[2][1]), 8);
    check("nom_b33", 32'(bus.acc_b[3][3]), 9);
    check("nom_b02", 32'(bus.acc_b[0][2]), 8);
    @(negedge clk);
    check("nom_ready_after", 32'(bus.job_ready), 1);

    // timeout, accelerator never completes
    lat = 0;
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    submit(8'h00, 8'h10, 8'h30);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check("to_done_cyc", 32'(dlog[d0] - alog[a0]), 43);
    check("to_done_err", 32'(done_err), 1);
    check("to_done_cnt", 32'(done_cnt - d0), 1);
    check("to_wr_count", 32'(wr_cnt - w0), 0);

    // reset in the middle of LOAD
    lat = 5;
    a0 = acc_cnt; d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    s0 = start_cnt;
    submit(8'h00, 8'h10, 8'h20);
    for (int i = 0; i < 40 && cyc < alog[a0] + 10; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(bus.job_ready), 1);
    check("rst_mid_rd_en", 32'(bus.mem_rd_en), 0);
    repeat (60) @(posedge clk);
    #1;
    check("rst_mid_rd_cnt", 32'(rd_cnt - r0), 10);
    check("rst_mid_start",  32'(start_cnt - s0), 0);
    check("rst_mid_done",   32'(done_cnt - d0), 0);
    check("rst_mid_wr",     32'(wr_cnt - w0), 0);

    // back-to-back jobs with job_valid held high
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt; s0 = start_cnt;
    @(posedge clk);
    #1;
    bus.job_addr_a = 8'h00;
    bus.job_addr_b = 8'h10;
    bus.job_addr_c = 8'h20;
    bus.job_valid  = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
      @(posedge clk);
      #1;
    end
    bus.job_addr_a = 8'h10;
    bus.job_addr_b = 8'h00;
    bus.job_addr_c = 8'h40;
    for (int i = 0; i < 200 && acc_cnt < a0 + 2; i++) begin
      @(posedge clk);
      #1;
    end
    bus.job_valid = 1'b0;
    check("b2b_accepts", 32'(acc_cnt - a0), 2);
    wait_done(d0 + 2);
    check("b2b_gap",      32'(alog[a0 + 1] - dlog[d0]), 1);
    check("b2b_done1",    32'(dlog[d0] - alog[a0]), 56);
    check("b2b_starts",   32'(start_cnt - s0), 2);
    check("b2b_wr_count", 32'(wr_cnt - w0), 32);
    check("b2b_wr1_addr", 32'(wlog[w0]), 32'h20);
    check("b2b_wr2_addr", 32'(wlog[w0 + 16]), 32'h40);
    check("b2b_c1_00",    32'(mem[8'h20]), 96);
    check("b2b_c2_00",    32'(mem[8'h40]), 59);
    check("b2b_c2_33",    32'(mem[8'h4F]), 87);

    // write address wraps past 0xFF
    a0 = acc_cnt; d0 = done_cnt; w0 = wr_cnt;
    submit(8'h00, 8'h10, 8'hF8);
    wait_done(d0 + 1);
    check("wrap_wr_count", 32'(wr_cnt - w0), 16);
    check("wrap_addr0",    32'(wlog[w0]), 32'hF8);
    check("wrap_addr7",    32'(wlog[w0 + 7]), 32'hFF);
    check("wrap_addr8",    32'(wlog[w0 + 8]), 32'h00);
    check("wrap_addr15",   32'(wlog[w0 + 15]), 32'h07);
    check("wrap_c00", 32'(mem[8'hF8]), 96);
    check("wrap_c13", 32'(mem[8'hFF]), 52);
    check("wrap_c20", 32'(mem[8'h00]), 58);
    check("wrap_c33", 32'(mem[8'h07]), 142);
    check("wrap_err", 32'(done_err), 0);

    check("port_exclusive", 32'(excl_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
